// File: rtl/bypass_buffer.sv
// Single-entry elastic buffer with a zero-latency combinational bypass.
// One word is held only when the consumer is not ready in the write cycle.
module bypass_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             write_enable,
  input  logic [WIDTH-1:0] write_data,
  output logic             full,
  input  logic             read_enable,
  output logic [WIDTH-1:0] read_data,
  output logic             empty
);

  logic             valid_q;
  logic             valid_d;
  logic [WIDTH-1:0] data_q;
  logic             load;

  // NOTE: every signal written here gets a default first so no path leaves
  // it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    valid_d = valid_q;
    load    = 1'b0;
    if (!valid_q) begin
      // Empty: a write is stored only if the consumer does not take it now.
      if (write_enable && !read_enable) begin
        valid_d = 1'b1;
        load    = 1'b1;
      end
    end else begin
      if (read_enable && write_enable) begin
        load = 1'b1;
      end else if (read_enable) begin
        valid_d = 1'b0;
      end
      // A write without a read while occupied is dropped (overflow).
    end
  end

  // NOTE: state uses non-blocking assignments so every flop samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // NOTE: the data register is given a defined reset value as well, so the
  // word is deterministic after reset even though valid gates its use.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      data_q <= '0;
    end else if (load) begin
      data_q <= write_data;
    end
  end

  assign read_data = valid_q ? data_q : write_data;
  assign empty     = !valid_q && !write_enable;
  assign full      = valid_q && !read_enable;

endmodule

// File: tb/tb_bypass_buffer.sv
// Directed self-checking bench for bypass_buffer: bypass, fill/drain,
// streaming, overflow/underflow, async reset and a bounded random run.
module tb_bypass_buffer;
  localparam int WIDTH = 8;

  logic             clock = 1'b0;
  logic             resetn = 1'b0;
  logic             write_enable = 1'b0;
  logic             read_enable = 1'b0;
  logic [WIDTH-1:0] write_data = '0;
  logic             full;
  logic             empty;
  logic [WIDTH-1:0] read_data;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  bypass_buffer #(.WIDTH(WIDTH)) dut (
    .clock        (clock),
    .resetn       (resetn),
    .write_enable (write_enable),
    .write_data   (write_data),
    .full         (full),
    .read_enable  (read_enable),
    .read_data    (read_data),
    .empty        (empty)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge, outputs are checked
  // 1 unit after that, well away from the next edge.
  task automatic drive(input logic we, input logic re, input logic [WIDTH-1:0] d);
    write_enable = we;
    read_enable  = re;
    write_data   = d;
    #1;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic flags(input string tag, input logic e, input logic f);
    check({tag, ".empty"}, {31'd0, empty}, {31'd0, e});
    check({tag, ".full"},  {31'd0, full},  {31'd0, f});
  endtask

  initial begin
    logic             mv;
    logic [WIDTH-1:0] md;
    logic             we;
    logic             re;
    logic [WIDTH-1:0] d;
    int               reads;
    int               cycles;

    // Reset and idle
    drive(1'b0, 1'b0, 8'h5A);
    flags("reset", 1'b1, 1'b0);
    check("reset.rd", {24'd0, read_data}, 32'h5A);
    repeat (2) @(posedge clock);
    #1 resetn = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      flags("idle", 1'b1, 1'b0);
    end

    // Bypass
    drive(1'b1, 1'b1, 8'hAA);
    check("bypass.rd", {24'd0, read_data}, 32'hAA);
    flags("bypass", 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 8'h33);
    flags("bypass.after", 1'b1, 1'b0);
    check("bypass.nostore", {24'd0, read_data}, 32'h33);

    // Fill then drain
    drive(1'b1, 1'b0, 8'hAA);
    flags("fill.wr", 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 8'h00);
    flags("fill", 1'b0, 1'b1);
    check("fill.rd", {24'd0, read_data}, 32'hAA);
    for (int i = 0; i < 10; i++) begin
      tick();
      flags("hold", 1'b0, 1'b1);
      check("hold.rd", {24'd0, read_data}, 32'hAA);
    end
    drive(1'b0, 1'b1, 8'h00);
    check("drain.rd", {24'd0, read_data}, 32'hAA);
    flags("drain", 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 8'h44);
    flags("drained", 1'b1, 1'b0);
    check("drained.rd", {24'd0, read_data}, 32'h44);

    // Alternating single transfers
    for (int i = 0; i < 100; i++) begin
      drive(1'b1, 1'b0, 8'(i));
      tick();
      drive(1'b0, 1'b0, ~8'(i));
      flags("alt.full", 1'b0, 1'b1);
      drive(1'b0, 1'b1, ~8'(i));
      check("alt.rd", {24'd0, read_data}, 32'(i));
      tick();
      drive(1'b0, 1'b0, 8'h00);
      flags("alt.empty", 1'b1, 1'b0);
    end

    // Continuous flow through an empty buffer
    for (int i = 0; i < 100; i++) begin
      drive(1'b1, 1'b1, 8'(i));
      check("flow0.rd", {24'd0, read_data}, 32'(i));
      flags("flow0", 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 1'b0, 8'hFF);
    flags("flow0.end", 1'b1, 1'b0);

    // Continuous flow through an occupied buffer
    drive(1'b1, 1'b0, 8'h00);
    tick();
    for (int i = 1; i <= 100; i++) begin
      drive(1'b1, 1'b1, 8'(i));
      check("flow1.rd", {24'd0, read_data}, 32'(i - 1));
      flags("flow1", 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 1'b1, 8'h00);
    check("flow1.last", {24'd0, read_data}, 32'd100);
    tick();
    drive(1'b0, 1'b0, 8'h00);
    flags("flow1.end", 1'b1, 1'b0);

    // Overflow: write while full is dropped
    drive(1'b1, 1'b0, 8'h11);
    tick();
    drive(1'b1, 1'b0, 8'h22);
    flags("ovf", 1'b0, 1'b1);
    tick();
    drive(1'b0, 1'b1, 8'h00);
    check("ovf.rd", {24'd0, read_data}, 32'h11);
    tick();
    drive(1'b0, 1'b0, 8'h00);
    flags("ovf.end", 1'b1, 1'b0);

    // Underflow: read while empty is ignored
    drive(1'b0, 1'b1, 8'h77);
    flags("udf", 1'b1, 1'b0);
    tick();
    drive(1'b0, 1'b0, 8'h78);
    flags("udf.end", 1'b1, 1'b0);
    check("udf.rd", {24'd0, read_data}, 32'h78);

    // Asynchronous reset while occupied
    drive(1'b1, 1'b0, 8'h99);
    tick();
    drive(1'b0, 1'b0, 8'h01);
    flags("arst.pre", 1'b0, 1'b1);
    #2 resetn = 1'b0;
    #1;
    flags("arst", 1'b1, 1'b0);
    check("arst.rd", {24'd0, read_data}, 32'h01);
    #2 resetn = 1'b1;
    tick();
    flags("arst.post", 1'b1, 1'b0);

    // Random traffic against a one-entry model
    mv = 1'b0;
    md = '0;
    reads = 0;
    cycles = 0;
    while (reads < 100 && cycles < 1000) begin
      d = 8'($urandom);
      if (mv) begin
        re = 1'($urandom);
        we = 1'($urandom) && re;
      end else begin
        we = 1'($urandom);
        re = 1'($urandom) && we;
      end
      drive(we, re, d);
      flags("rnd", !mv && !we, mv && !re);
      if (re) begin
        check("rnd.rd", {24'd0, read_data}, {24'd0, (mv ? md : d)});
        reads++;
      end
      if (!mv) begin
        if (we && !re) begin
          mv = 1'b1;
          md = d;
        end
      end else if (re && we) begin
        md = d;
      end else if (re) begin
        mv = 1'b0;
      end
      tick();
      cycles++;
    end
    check("rnd.done", {31'd0, (reads >= 100)}, 32'd1);
    if (mv) begin
      drive(1'b0, 1'b1, 8'h00);
      check("rnd.drain", {24'd0, read_data}, {24'd0, md});
      tick();
    end
    drive(1'b0, 1'b0, 8'h00);
    flags("rnd.end", 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
